// File: rtl/test_monitor.sv
// test_monitor: PC-watch self-check monitor with watchdog and sticky PASS/FAIL/TIMEOUT verdict.
// Define TMON_HITCNT_EN to add per-channel hit counters gated by cfg_cnt.
module test_monitor #(
    parameter int XLEN = 32,
    parameter int NCH = 4,
    parameter int TMO_W = 16,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CW-1:0]     cfg_sel,
    input  logic              cfg_en,
    input  logic              cfg_kind,
    input  logic [XLEN-1:0]   cfg_pc,
    input  logic [XLEN-1:0]   cfg_exp,
    input  logic [7:0]        cfg_cnt,
    input  logic              start,
    input  logic [TMO_W-1:0]  tmo_limit,
    input  logic              pc_valid,
    input  logic [XLEN-1:0]   pc,
    input  logic [NCH*XLEN-1:0] chk_val,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [CW-1:0]     hit_ch,
    output logic [TMO_W-1:0]  cycles
);
    typedef enum logic [2:0] {IDLE, RUN, PASS, FAIL, TIMEOUT} state_t;
    state_t state;
    logic [NCH-1:0] ch_en, ch_kind, match, dec, ok;
    logic [XLEN-1:0] ch_pc [NCH];
    logic [XLEN-1:0] ch_exp [NCH];
    logic any;
    logic [CW-1:0] win;
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            match[i] = ch_en[i] && pc_valid && pc == ch_pc[i];
            ok[i] = chk_val[i*XLEN +: XLEN] == ch_exp[i];
        end
    end
    // Scan downward so the lowest deciding index is the one left standing.
    always_comb begin
        any = 1'b0;
        win = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (dec[i]) begin
                any = 1'b1;
                win = CW'(i);
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_en <= '0;
            ch_kind <= '0;
            for (int i = 0; i < NCH; i++) begin
                ch_pc[i] <= '0;
                ch_exp[i] <= '0;
            end
        end else if (cfg_we && state != RUN) begin
            ch_en[cfg_sel] <= cfg_en;
            ch_kind[cfg_sel] <= cfg_kind;
            ch_pc[cfg_sel] <= cfg_pc;
            ch_exp[cfg_sel] <= cfg_exp;
        end
    end
`ifdef TMON_HITCNT_EN
    logic [7:0] ch_cnt [NCH];
    logic [7:0] hits [NCH];
    logic [7:0] need [NCH];
    // A match only decides on the hit that brings the count up to the target.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            need[i] = (ch_cnt[i] == 8'd0) ? 8'd1 : ch_cnt[i];
            dec[i] = match[i] && (hits[i] + 8'd1 == need[i]);
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                ch_cnt[i] <= '0;
                hits[i] <= '0;
            end
        end else begin
            if (cfg_we && state != RUN)
                ch_cnt[cfg_sel] <= cfg_cnt;
            for (int i = 0; i < NCH; i++) begin
                if (start)
                    hits[i] <= '0;
                else if (state == RUN && match[i] && hits[i] != need[i])
                    hits[i] <= hits[i] + 8'd1;
            end
        end
    end
`else
    logic unused_cnt;
    assign unused_cnt = ^cfg_cnt;
    assign dec = match;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cycles <= '0;
            hit_ch <= '0;
        end else if (start) begin
            state <= RUN;
            cycles <= '0;
            hit_ch <= '0;
        end else if (state == RUN) begin
            cycles <= (&cycles) ? cycles : cycles + TMO_W'(1);
            if (any) begin
                hit_ch <= win;
                state <= (!ch_kind[win] && ok[win]) ? PASS : FAIL;
            end else if (tmo_limit != '0 && cycles == tmo_limit - TMO_W'(1)) begin
                state <= TIMEOUT;
            end
        end
    end
    assign running = state == RUN;
    assign pass = state == PASS;
    assign timeout = state == TIMEOUT;
    assign fail = state == FAIL || state == TIMEOUT;
    assign done = pass || fail;
endmodule

// File: tb/tb_test_monitor.sv
// tb_test_monitor: directed self-checking bench for test_monitor (default build or TMON_HITCNT_EN).
module tb_test_monitor;
    localparam int XLEN = 32;
    localparam int NCH = 4;
    localparam int TMO_W = 16;
    localparam int CW = 2;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cfg_we = 1'b0, cfg_en = 1'b0, cfg_kind = 1'b0, start = 1'b0, pc_valid = 1'b0;
    logic [CW-1:0] cfg_sel = '0;
    logic [XLEN-1:0] cfg_pc = '0, cfg_exp = '0, pc = '0;
    logic [7:0] cfg_cnt = '0;
    logic [TMO_W-1:0] tmo_limit = '0;
    logic [NCH*XLEN-1:0] chk_val = '0;
    logic running, done, pass, fail, timeout;
    logic [CW-1:0] hit_ch;
    logic [TMO_W-1:0] cycles;
    int errors = 0;
    int checks = 0;

    test_monitor #(.XLEN(XLEN), .NCH(NCH), .TMO_W(TMO_W)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_en(cfg_en),
        .cfg_kind(cfg_kind), .cfg_pc(cfg_pc), .cfg_exp(cfg_exp), .cfg_cnt(cfg_cnt),
        .start(start), .tmo_limit(tmo_limit), .pc_valid(pc_valid), .pc(pc), .chk_val(chk_val),
        .running(running), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .hit_ch(hit_ch), .cycles(cycles)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic cfg(input int ch, input logic en, input logic kind,
                       input logic [XLEN-1:0] p, input logic [XLEN-1:0] e, input logic [7:0] n);
        cfg_sel = CW'(ch);
        cfg_en = en;
        cfg_kind = kind;
        cfg_pc = p;
        cfg_exp = e;
        cfg_cnt = n;
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // status vector order: {running, done, pass, fail, timeout}
    task automatic test_reset;
        #1;
        checks++;
        if ({running, done, pass, fail, timeout} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_status: got %b expected 00000", {running, done, pass, fail, timeout});
        end
        checks++;
        if (hit_ch !== 2'd0) begin
            errors++;
            $display("FAIL reset_hit_ch: got %0d expected 0", hit_ch);
        end
        checks++;
        if (cycles !== 16'd0) begin
            errors++;
            $display("FAIL reset_cycles: got %h expected 0000", cycles);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_pass;
        cfg(0, 1'b1, 1'b0, 32'h44, 32'h0, 8'd0);
        do_start();
        checks++;
        if ({running, done, pass, fail, timeout} !== 5'b10000 || cycles !== 16'd0) begin
            errors++;
            $display("FAIL pass_start: got %b cycles=%h expected 10000 cycles=0000",
                     {running, done, pass, fail, timeout}, cycles);
        end
        for (int p = 0; p <= 32'h40; p += 4) begin
            pc_valid = 1'b1;
            pc = p;
            chk_val[31:0] = 32'hdead_beef;
            tick();
        end
        checks++;
        if ({running, done, pass, fail, timeout} !== 5'b10000 || cycles !== 16'd17) begin
            errors++;
            $display("FAIL pass_walk: got %b cycles=%h expected 10000 cycles=0011",
                     {running, done, pass, fail, timeout}, cycles);
        end
        pc = 32'h44;
        chk_val[31:0] = 32'h0;
        tick();
        pc_valid = 1'b0;
        checks++;
        if ({running, done, pass, fail, timeout} !== 5'b01100 || hit_ch !== 2'd0 || cycles !== 16'd18) begin
            errors++;
            $display("FAIL pass_verdict: got %b hit=%0d cycles=%h expected 01100 hit=0 cycles=0012",
                     {running, done, pass, fail, timeout}, hit_ch, cycles);
        end
        repeat (20) tick();
        checks++;
        if ({running, done, pass, fail, timeout} !== 5'b01100 || cycles !== 16'd18) begin
            errors++;
            $display("FAIL pass_sticky: got %b cycles=%h expected 01100 cycles=0012",
                     {running, done, pass, fail, timeout}, cycles);
        end
    endtask

    task automatic test_fail;
        do_start();
        checks++;
        if ({running, done, pass, fail, timeout} !== 5'b10000 || cycles !== 16'd0) begin
            errors++;
            $display("FAIL fail_restart: got %b cycles=%h expected 10000 cycles=0000",
                     {running, done, pass, fail, timeout}, cycles);
        end
        pc_valid = 1'b1;
        chk_val[31:0] = 32'h1;
        pc = 32'h40;
        tick();
        pc = 32'h44;
        tick();
        pc_valid = 1'b0;
        checks++;
        if ({running, done, pass, fail, timeout} !== 5'b01010 || hit_ch !== 2'd0) begin
            errors++;
            $display("FAIL fail_verdict: got %b hit=%0d expected 01010 hit=0",
                     {running, done, pass, fail, timeout}, hit_ch);
        end
    endtask

    task automatic test_watchdog;
        tmo_limit = 16'h0215;
        do_start();
        repeat (16'h0214) tick();
        checks++;
        if ({running, done, pass, fail, timeout} !== 5'b10000 || cycles !== 16'h0214) begin
            errors++;
            $display("FAIL wdog_before: got %b cycles=%h expected 10000 cycles=0214",
                     {running, done, pass, fail, timeout}, cycles);
        end
        tick();
        checks++;
        if ({running, done, pass, fail, timeout} !== 5'b01011 || cycles !== 16'h0215 || hit_ch !== 2'd0) begin
            errors++;
            $display("FAIL wdog_expire: got %b cycles=%h hit=%0d expected 01011 cycles=0215 hit=0",
                     {running, done, pass, fail, timeout}, cycles, hit_ch);
        end
        do_start();
        repeat (16'h0214) tick();
        pc_valid = 1'b1;
        pc = 32'h44;
        chk_val[31:0] = 32'h0;
        tick();
        pc_valid = 1'b0;
        checks++;
        if ({running, done, pass, fail, timeout} !== 5'b01100 || cycles !== 16'h0215) begin
            errors++;
            $display("FAIL wdog_match_wins: got %b cycles=%h expected 01100 cycles=0215",
                     {running, done, pass, fail, timeout}, cycles);
        end
        tmo_limit = 16'h0;
    endtask

    task automatic test_priority;
        cfg(1, 1'b1, 1'b1, 32'h80, 32'h0, 8'd0);
        cfg(2, 1'b1, 1'b0, 32'h80, 32'h1234_5678, 8'd0);
        chk_val[95:64] = 32'h1234_5678;
        do_start();
        pc_valid = 1'b1;
        pc = 32'h80;
        tick();
        pc_valid = 1'b0;
        checks++;
        if ({running, done, pass, fail, timeout} !== 5'b01010 || hit_ch !== 2'd1) begin
            errors++;
            $display("FAIL prio_trap: got %b hit=%0d expected 01010 hit=1",
                     {running, done, pass, fail, timeout}, hit_ch);
        end
        cfg(1, 1'b0, 1'b1, 32'h80, 32'h0, 8'd0);
        do_start();
        pc_valid = 1'b1;
        pc = 32'h80;
        tick();
        pc_valid = 1'b0;
        checks++;
        if ({running, done, pass, fail, timeout} !== 5'b01100 || hit_ch !== 2'd2) begin
            errors++;
            $display("FAIL prio_disabled: got %b hit=%0d expected 01100 hit=2",
                     {running, done, pass, fail, timeout}, hit_ch);
        end
        do_start();
        cfg(3, 1'b1, 1'b1, 32'h90, 32'h0, 8'd0);
        pc_valid = 1'b1;
        pc = 32'h90;
        tick();
        checks++;
        if ({running, done, pass, fail, timeout} !== 5'b10000) begin
            errors++;
            $display("FAIL cfg_in_run: got %b expected 10000", {running, done, pass, fail, timeout});
        end
        pc = 32'h80;
        tick();
        pc_valid = 1'b0;
        checks++;
        if ({running, done, pass, fail, timeout} !== 5'b01100 || hit_ch !== 2'd2) begin
            errors++;
            $display("FAIL cfg_in_run_end: got %b hit=%0d expected 01100 hit=2",
                     {running, done, pass, fail, timeout}, hit_ch);
        end
    endtask

    task automatic test_hitcnt;
        logic exp_done;
        cfg(0, 1'b1, 1'b0, 32'h10, 32'h0, 8'd3);
        chk_val[31:0] = 32'h0;
        do_start();
        for (int k = 0; k < 3; k++) begin
            pc_valid = 1'b1;
            pc = 32'h10;
            tick();
`ifdef TMON_HITCNT_EN
            exp_done = (k == 2);
`else
            exp_done = 1'b1;
`endif
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL hitcnt_hit%0d: got done=%b expected %b", k, done, exp_done);
            end
            pc = 32'h0c;
            tick();
        end
        pc_valid = 1'b0;
        checks++;
        if ({running, done, pass, fail, timeout} !== 5'b01100 || hit_ch !== 2'd0) begin
            errors++;
            $display("FAIL hitcnt_verdict: got %b hit=%0d expected 01100 hit=0",
                     {running, done, pass, fail, timeout}, hit_ch);
        end
    endtask

    task automatic test_back_to_back;
        do_start();
        repeat (5) tick();
        checks++;
        if (cycles !== 16'd5) begin
            errors++;
            $display("FAIL restart_count: got %h expected 0005", cycles);
        end
        do_start();
        checks++;
        if ({running, done, pass, fail, timeout} !== 5'b10000 || cycles !== 16'd0) begin
            errors++;
            $display("FAIL restart_in_run: got %b cycles=%h expected 10000 cycles=0000",
                     {running, done, pass, fail, timeout}, cycles);
        end
    endtask

    task automatic test_reset_mid;
        do_start();
        repeat (16'h30) tick();
        checks++;
        if (cycles !== 16'h0030 || running !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got cycles=%h running=%b expected 0030 1", cycles, running);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({running, done, pass, fail, timeout} !== 5'b00000 || hit_ch !== 2'd0 || cycles !== 16'd0) begin
            errors++;
            $display("FAIL mid_async: got %b hit=%0d cycles=%h expected 00000 hit=0 cycles=0000",
                     {running, done, pass, fail, timeout}, hit_ch, cycles);
        end
        @(negedge clk);
        reset = 1'b0;
        do_start();
        pc_valid = 1'b1;
        chk_val = '0;
        pc = 32'h10;
        tick();
        pc = 32'h44;
        tick();
        pc = 32'h80;
        tick();
        pc_valid = 1'b0;
        checks++;
        if ({running, done, pass, fail, timeout} !== 5'b10000 || cycles !== 16'd3) begin
            errors++;
            $display("FAIL mid_no_enables: got %b cycles=%h expected 10000 cycles=0003",
                     {running, done, pass, fail, timeout}, cycles);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_watchdog();
        test_priority();
        test_hitcnt();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
